// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider with burst and graceful stop.
// Divisor updates are deferred to period boundaries in RUN.
module clkdiv_ctrl #(
  parameter int WIDTH   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               cfg_valid,
  input  logic [WIDTH-1:0]   cfg_div,
  output logic               cfg_ready,
  output logic               clkout,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic               pvld_q, pvld_d;
  logic [BURST_W-1:0] edges_q, edges_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               sreq_q, sreq_d;
  logic               clk_q, clk_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;

  logic cfg_acc;
  logic at_top;
  logic last;

  assign cfg_acc   = cfg_valid && !pvld_q;
  assign at_top    = (cnt_q == div_q);
  assign last      = sreq_q ||
                     ((burst_q != '0) && (edges_q == burst_q));

  assign cfg_ready = !pvld_q;
  assign clkout    = clk_q;
  assign tick      = tick_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;

  // State register; reset drops clkout at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      pend_q  <= '0;
      pvld_q  <= 1'b0;
      edges_q <= '0;
      burst_q <= '0;
      sreq_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      edges_q <= edges_d;
      burst_q <= burst_d;
      sreq_q  <= sreq_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  // Next state: phase counting, boundary decisions, cfg handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    edges_d = edges_q;
    burst_d = burst_q;
    sreq_d  = sreq_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (pvld_q) begin
          div_d  = pend_q;
          pvld_d = 1'b0;
        end else if (cfg_acc) begin
          div_d = cfg_div;
        end
        if (start && !stop) begin
          state_d = RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
          edges_d = {{(BURST_W-1){1'b0}}, 1'b1};
          burst_d = burst_len;
        end
      end
      RUN: begin
        if (stop) sreq_d = 1'b1;
        if (cfg_acc) begin
          pend_d = cfg_div;
          pvld_d = 1'b1;
        end
        if (at_top) begin
          cnt_d = '0;
          if (clk_q) begin
            clk_d = 1'b0;
          end else if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            sreq_d  = 1'b0;
            edges_d = '0;
            if (pvld_q) begin
              div_d  = pend_q;
              pvld_d = 1'b0;
            end
          end else begin
            clk_d  = 1'b1;
            tick_d = 1'b1;
            if (edges_q != '1) edges_d = edges_q + 1'b1;
            if (pvld_q) begin
              div_d  = pend_q;
              pvld_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Scoreboard bench for clkdiv_ctrl: expected tick/done
// events are queued by stimulus and popped by a monitor.
module tb_clkdiv_ctrl;

  localparam int WIDTH   = 16;
  localparam int BURST_W = 8;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic [BURST_W-1:0] burst_len;
  logic               cfg_valid;
  logic [WIDTH-1:0]   cfg_div;
  logic               cfg_ready;
  logic               clkout;
  logic               tick;
  logic               busy;
  logic               done;

  clkdiv_ctrl #(.WIDTH(WIDTH), .BURST_W(BURST_W)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .clkout    (clkout),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    bit is_done;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  cyc    = 0;
  int  n_run  = 0;
  int  n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, longint got, longint exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d required=%0d",
               nm, cyc, got, exp);
    end
  endtask

  task automatic push(bit d, int c);
    ev_t e;
    e.is_done = d;
    e.cyc     = c;
    q.push_back(e);
  endtask

  // Monitor: every tick/done pulse must match the queue head.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (tick || done)) begin
      if (q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d tick=%0b done=%0b required=none",
                 cyc, tick, done);
      end else begin
        e = q.pop_front();
        chk("event_kind_done", done, e.is_done);
        chk("event_kind_tick", tick, !e.is_done);
        chk("event_cycle", cyc, e.cyc);
        if (done) begin
          chk("done_clkout", clkout, 0);
          chk("done_busy", busy, 0);
        end
      end
    end
  end

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_cfg(int d);
    cfg_valid = 1'b1;
    cfg_div   = WIDTH'(d);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_start(int b, output int s);
    start     = 1'b1;
    burst_len = BURST_W'(b);
    s         = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_empty(string nm);
    chk(nm, q.size(), 0);
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    burst_len = '0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    #2;
    chk("rst_clkout", clkout, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // D=3 continuous, stop in 2nd high cycle of 3rd period
    do_cfg(3);
    chk("idle_cfg_ready", cfg_ready, 1);
    do_start(0, s);
    push(0, s);
    push(0, s + 8);
    push(0, s + 16);
    push(1, s + 24);
    for (int x = s; x < s + 24; x++) begin
      wait_cyc(x);
      chk("d3_clkout", clkout, ((x - s) % 8) < 4);
      chk("d3_busy", busy, 1);
      stop = (x == s + 17);
    end
    stop = 1'b0;
    wait_cyc(s + 26);
    chk("d3_end_busy", busy, 0);
    chk("d3_end_clkout", clkout, 0);
    chk_empty("d3_queue");

    // D=1 burst of 2
    do_cfg(1);
    do_start(2, s);
    push(0, s);
    push(0, s + 4);
    push(1, s + 8);
    wait_cyc(s + 7);
    chk("b2_busy_pre", busy, 1);
    wait_cyc(s + 9);
    chk("b2_busy_post", busy, 0);
    wait_cyc(s + 12);
    chk("b2_clkout_idle", clkout, 0);
    chk_empty("b2_queue");

    // D=3 running, retarget to D=0 mid-period
    do_cfg(3);
    do_start(0, s);
    push(0, s);
    for (int k = 8; k <= 16; k += 2) push(0, s + k);
    wait_cyc(s + 2);
    do_cfg(0);
    chk("pend_ready_lo", cfg_ready, 0);
    do_cfg(5);
    for (int x = s + 5; x < s + 8; x++) begin
      wait_cyc(x);
      chk("pend_ready_hold", cfg_ready, 0);
    end
    wait_cyc(s + 8);
    chk("pend_ready_hi", cfg_ready, 1);
    for (int x = s + 8; x < s + 16; x++) begin
      wait_cyc(x);
      chk("d0_clkout", clkout, ((x - s) % 2) == 0);
    end

    // Reset mid-high
    wait_cyc(s + 16);
    #1;
    chk("pre_rst_clkout", clkout, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_clkout", clkout, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    chk_empty("d0_queue");
    @(negedge clk);

    // After reset div_act is 0: period 2, then stop
    do_start(0, s);
    push(0, s);
    push(0, s + 2);
    push(0, s + 4);
    push(1, s + 6);
    wait_cyc(s + 1);
    chk("r0_clkout_low", clkout, 0);
    wait_cyc(s + 4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_cyc(s + 9);
    chk("r0_busy_end", busy, 0);
    chk_empty("r0_queue");

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    s = cyc;
    wait_cyc(s + 6);
    chk("ss_busy", busy, 0);
    chk("ss_clkout", clkout, 0);
    chk_empty("ss_queue");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
